// File: rtl/pipe_state_dumper.sv
// Streams a latched pipeline snapshot, the register file and data memory as
// a byte frame into the UART TX FIFO: header, bundle bytes, register words, memory words.
module pipe_state_dumper #(
  parameter int unsigned NB_REG   = 32,
  parameter int unsigned NB_R_INT = 376,
  parameter int unsigned N_REGS   = 32,
  parameter int unsigned N_MEM    = 32,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_R_INT-1:0] i_reg_int,
  input  logic [NB_REG-1:0]   i_reg_data,
  input  logic [NB_REG-1:0]   i_mem_data,
  input  logic                i_tx_full,
  output logic [NB_REG-1:0]   o_addr,
  output logic                o_wr_tx,
  output logic [7:0]          o_tx_data,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned INT_BYTES  = NB_R_INT / 8;
  localparam int unsigned WORD_BYTES = NB_REG / 8;
  localparam int unsigned CNT_W      = $clog2(INT_BYTES + WORD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_INT, S_RD_ADDR, S_RD_SEND, S_DONE
  } state_t;

  state_t              state_q,     state_d;
  logic [NB_R_INT-1:0] shadow_q,    shadow_d;
  logic [NB_REG-1:0]   word_q,      word_d;
  logic [NB_REG-1:0]   idx_q,       idx_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                mem_phase_q, mem_phase_d;
  logic                have_word_q, have_word_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                send_c;
  logic                wr_c;

  // A byte is offered whenever a send state holds valid data; the FIFO full
  // flag gates the strobe in the same cycle so nothing is lost or repeated.
  always_comb begin
    send_c = (state_q == S_HDR) || (state_q == S_INT) ||
             ((state_q == S_RD_SEND) && have_word_q);
    wr_c   = send_c && !i_tx_full;
  end

  always_comb begin
    o_tx_data = 8'h00;
    case (state_q)
      S_HDR:   o_tx_data = HDR_BYTE;
      S_INT:   o_tx_data = shadow_q[NB_R_INT-1 -: 8];
      S_RD_SEND: if (have_word_q) o_tx_data = word_q[NB_REG-1 -: 8];
      default: o_tx_data = 8'h00;
    endcase
  end

  // Next-state: bundle and words are shifted left so the outgoing byte is always the top one.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    word_d      = word_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    mem_phase_d = mem_phase_q;
    have_word_d = have_word_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          shadow_d    = i_reg_int;
          cnt_d       = '0;
          idx_d       = '0;
          mem_phase_d = 1'b0;
          have_word_d = 1'b0;
          state_d     = S_HDR;
        end
      end
      S_HDR: begin
        if (wr_c) begin
          cnt_d   = '0;
          state_d = S_INT;
        end
      end
      S_INT: begin
        if (wr_c) begin
          shadow_d = shadow_q << 8;
          if (cnt_q == CNT_W'(INT_BYTES - 1)) begin
            cnt_d       = '0;
            idx_d       = '0;
            mem_phase_d = 1'b0;
            state_d     = S_RD_ADDR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RD_ADDR: begin
        have_word_d = 1'b0;
        state_d     = S_RD_SEND;
      end
      S_RD_SEND: begin
        if (!have_word_q) begin
          word_d      = mem_phase_q ? i_mem_data : i_reg_data;
          have_word_d = 1'b1;
        end else if (wr_c) begin
          word_d = word_q << 8;
          if (cnt_q == CNT_W'(WORD_BYTES - 1)) begin
            cnt_d       = '0;
            have_word_d = 1'b0;
            state_d     = S_RD_ADDR;
            if (!mem_phase_q) begin
              if (idx_q == NB_REG'(N_REGS - 1)) begin
                mem_phase_d = 1'b1;
                idx_d       = '0;
              end else begin
                idx_d = idx_q + NB_REG'(1);
              end
            end else if (idx_q == NB_REG'(N_MEM - 1)) begin
              idx_d   = '0;
              state_d = S_DONE;
            end else begin
              idx_d = idx_q + NB_REG'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      mem_phase_q <= 1'b0;
      have_word_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mem_phase_q <= mem_phase_d;
      have_word_q <= have_word_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_addr  = idx_q;
  assign o_wr_tx = wr_c;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_pipe_state_dumper.sv
// Randomized bench for pipe_state_dumper: frames are compared against a byte
// list built directly from the frame layout (header, bundle, regs, mem).
module tb_pipe_state_dumper;
  localparam int unsigned NB_REG   = 32;
  localparam int unsigned NB_R_INT = 376;
  localparam int unsigned N_REGS   = 32;
  localparam int unsigned N_MEM    = 32;
  localparam int          FRAME    = 1 + NB_R_INT / 8 + 4 * N_REGS + 4 * N_MEM;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                i_start;
  logic [NB_R_INT-1:0] i_reg_int;
  logic [NB_REG-1:0]   i_reg_data;
  logic [NB_REG-1:0]   i_mem_data;
  logic                i_tx_full;
  logic [NB_REG-1:0]   o_addr;
  logic                o_wr_tx;
  logic [7:0]          o_tx_data;
  logic                o_busy;
  logic                o_done;

  always #5 clk = ~clk;

  pipe_state_dumper dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(i_start), .i_reg_int(i_reg_int),
    .i_reg_data(i_reg_data), .i_mem_data(i_mem_data), .i_tx_full(i_tx_full),
    .o_addr(o_addr), .o_wr_tx(o_wr_tx), .o_tx_data(o_tx_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  logic [31:0] reg_arr [N_REGS];
  logic [31:0] mem_arr [N_MEM];

  // Synchronous-read register file and data memory models
  always @(posedge clk) begin
    i_reg_data <= (o_addr < NB_REG'(N_REGS)) ? reg_arr[o_addr[4:0]] : 32'hDEAD_BEEF;
    i_mem_data <= (o_addr < NB_REG'(N_MEM))  ? mem_arr[o_addr[4:0]] : 32'hDEAD_BEEF;
  end

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         done_len_q [$];
  int         addr_v [$];
  int         addr_len [$];
  int         done_cnt = 0;
  int         full_viol = 0;
  int         done_busy_viol = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  // Output monitor, sampled mid-cycle
  initial begin
    bit in_run;
    int last_addr;
    in_run = 1'b0;
    last_addr = 0;
    forever begin
      @(negedge clk);
      if (o_wr_tx) begin
        got_q.push_back(o_tx_data);
        if (i_tx_full) full_viol++;
      end
      if (o_done) begin
        done_cnt++;
        done_len_q.push_back(got_q.size());
        if (o_busy) done_busy_viol++;
      end
      if (o_busy) begin
        if (!in_run || int'(o_addr) != last_addr) begin
          addr_v.push_back(int'(o_addr));
          addr_len.push_back(1);
        end else begin
          addr_len[addr_len.size()-1] = addr_len[addr_len.size()-1] + 1;
        end
        in_run = 1'b1;
        last_addr = int'(o_addr);
      end else begin
        in_run = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  function automatic logic [NB_R_INT-1:0] rand_bundle();
    logic [NB_R_INT-1:0] r;
    for (int k = 0; k < NB_R_INT / 8; k++) r[k*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic void fill_mem(input bit pattern);
    for (int i = 0; i < N_REGS; i++) reg_arr[i] = pattern ? 32'(i) : $urandom;
    for (int i = 0; i < N_MEM; i++)  mem_arr[i] = pattern ? 32'h100 + 32'(i) : $urandom;
  endfunction

  // Reference frame: header, bundle MSB byte first, then each word MSB first
  function automatic void build_exp(input logic [NB_R_INT-1:0] b);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < NB_R_INT / 8; k++) exp_q.push_back(b[NB_R_INT-1-8*k -: 8]);
    for (int r = 0; r < N_REGS; r++)
      for (int j = 3; j >= 0; j--) exp_q.push_back(reg_arr[r][8*j +: 8]);
    for (int m = 0; m < N_MEM; m++)
      for (int j = 3; j >= 0; j--) exp_q.push_back(mem_arr[m][8*j +: 8]);
  endfunction

  function automatic int first_diff(input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= got_q.size()) return i;
      if (got_q[base+i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] get_word(input int idx);
    if (idx + 3 < got_q.size())
      return {got_q[idx], got_q[idx+1], got_q[idx+2], got_q[idx+3]};
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [7:0] got_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 8'hxx;
  endfunction

  task automatic start_frame(input logic [NB_R_INT-1:0] b);
    @(posedge clk); #1;
    i_reg_int = b;
    i_start   = 1'b1;
    @(posedge clk); #1;
    i_start   = 1'b0;
  endtask

  // Runs the frame until o_done or a cycle budget, applying the chosen disturbances
  task automatic wait_done(input int base, input bit bp, input bit mut, input bit pulses,
                           input int abort_at, output bit done_ok);
    int dbase;
    bit p1, p2;
    dbase = done_cnt;
    p1 = 1'b0;
    p2 = 1'b0;
    done_ok = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      i_tx_full = bp ? (((cyc / 3) % 2) == 0) : 1'b0;
      i_start = 1'b0;
      if (mut) i_reg_int = rand_bundle();
      if (pulses && !p1 && got_q.size() - base >= 10) begin
        i_start = 1'b1; p1 = 1'b1; i_reg_int = rand_bundle();
      end
      if (pulses && !p2 && got_q.size() - base >= 200) begin
        i_start = 1'b1; p2 = 1'b1; i_reg_int = rand_bundle();
      end
      if (abort_at > 0 && got_q.size() - base >= abort_at) begin
        rst_n = 1'b0;
        i_tx_full = 1'b0;
        done_ok = 1'b1;
        return;
      end
      @(negedge clk); #1;
      if (done_cnt != dbase) begin
        i_tx_full = 1'b0;
        done_ok = 1'b1;
        return;
      end
    end
    i_tx_full = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_tx_full = 1'b0; i_reg_int = '0;
    #1;
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", o_done); end
    n_cmp++; if (o_wr_tx !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %b expected 0", o_wr_tx); end
    n_cmp++; if (o_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0h expected 0", o_addr); end
    n_cmp++; if (o_tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %02h expected 00", o_tx_data); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (o_busy !== 1'b0 || got_q.size() != 0) begin
      n_err++; $display("FAIL idle_quiet: busy %b bytes %0d expected 0/0", o_busy, got_q.size());
    end
  endtask

  task automatic test_basic();
    logic [NB_R_INT-1:0] b;
    int base, abase, dbase, d, badv, minlen;
    bit ok;
    for (int k = 0; k < NB_R_INT / 8; k++) b[NB_R_INT-1-8*k -: 8] = 8'(k);
    fill_mem(1'b1);
    build_exp(b);
    base = got_q.size(); abase = addr_v.size(); dbase = done_cnt;
    start_frame(b);
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", o_busy); end
    wait_done(base, 1'b0, 1'b0, 1'b0, 0, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout: done %0d expected 1", ok); end
    n_cmp++; if (got_q.size() - base !== FRAME) begin
      n_err++; $display("FAIL basic_len: got %0d bytes expected %0d", got_q.size() - base, FRAME);
    end
    d = first_diff(base);
    n_cmp++; if (d != -1) begin
      n_err++; $display("FAIL basic_bytes: byte %0d got %02h expected %02h", d, got_at(base+d), exp_q[d]);
    end
    n_cmp++; if (got_at(base) !== 8'hA5) begin n_err++; $display("FAIL basic_hdr: got %02h expected a5", got_at(base)); end
    n_cmp++; if (got_at(base+47) !== 8'h2E) begin n_err++; $display("FAIL basic_int_last: got %02h expected 2e", got_at(base+47)); end
    n_cmp++; if (get_word(base + 48 + 20) !== 32'h0000_0005) begin
      n_err++; $display("FAIL basic_reg5: got %08h expected 00000005", get_word(base + 48 + 20));
    end
    n_cmp++; if (get_word(base + 300) !== 32'h0000_011F) begin
      n_err++; $display("FAIL basic_mem31: got %08h expected 0000011f", get_word(base + 300));
    end
    n_cmp++; if (done_len_q.size() == 0 || done_len_q[done_len_q.size()-1] - base != FRAME) begin
      n_err++; $display("FAIL basic_done_pos: bytes before done %0d expected %0d",
                        (done_len_q.size() == 0) ? -1 : done_len_q[done_len_q.size()-1] - base, FRAME);
    end
    n_cmp++; if (addr_v.size() - abase != N_REGS + N_MEM) begin
      n_err++; $display("FAIL addr_count: got %0d runs expected %0d", addr_v.size() - abase, N_REGS + N_MEM);
    end
    badv = -1; minlen = 1000;
    for (int i = 0; i < addr_v.size() - abase && i < N_REGS + N_MEM; i++) begin
      if (badv < 0 && addr_v[abase+i] != (i % 32)) badv = i;
      if (addr_len[abase+i] < minlen) minlen = addr_len[abase+i];
    end
    n_cmp++; if (badv >= 0) begin
      n_err++; $display("FAIL addr_seq: run %0d got %0d expected %0d", badv, addr_v[abase+badv], badv % 32);
    end
    n_cmp++; if (minlen < 5) begin n_err++; $display("FAIL addr_hold: min hold %0d expected >= 5", minlen); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt - dbase != 1 || done_busy_viol != 0) begin
      n_err++; $display("FAIL basic_done: pulses %0d busy-in-done %0d expected 1/0", done_cnt - dbase, done_busy_viol);
    end
  endtask

  task automatic test_backpressure();
    logic [NB_R_INT-1:0] b;
    int base, d;
    bit ok;
    b = rand_bundle(); fill_mem(1'b0); build_exp(b);
    base = got_q.size();
    start_frame(b);
    wait_done(base, 1'b1, 1'b0, 1'b0, 0, ok);
    d = first_diff(base);
    n_cmp++; if (!ok || got_q.size() - base !== FRAME || d != -1) begin
      n_err++; $display("FAIL bp_frame: done %0d len %0d first diff %0d expected 1/%0d/-1", ok, got_q.size() - base, FRAME, d);
    end
    n_cmp++; if (full_viol != 0) begin n_err++; $display("FAIL bp_wr_while_full: got %0d expected 0", full_viol); end
  endtask

  task automatic test_mutate();
    logic [NB_R_INT-1:0] b;
    int base, d;
    bit ok;
    b = rand_bundle(); fill_mem(1'b0); build_exp(b);
    base = got_q.size();
    start_frame(b);
    wait_done(base, 1'b0, 1'b1, 1'b0, 0, ok);
    d = first_diff(base);
    n_cmp++; if (!ok || got_q.size() - base !== FRAME || d != -1) begin
      n_err++; $display("FAIL mutate_frame: done %0d len %0d first diff %0d expected 1/%0d/-1", ok, got_q.size() - base, FRAME, d);
    end
  endtask

  task automatic test_start_while_busy();
    logic [NB_R_INT-1:0] b;
    int base, dbase, d;
    bit ok;
    b = rand_bundle(); fill_mem(1'b0); build_exp(b);
    base = got_q.size(); dbase = done_cnt;
    start_frame(b);
    wait_done(base, 1'b0, 1'b0, 1'b1, 0, ok);
    repeat (20) @(posedge clk);
    #1;
    d = first_diff(base);
    n_cmp++; if (!ok || got_q.size() - base !== FRAME || d != -1) begin
      n_err++; $display("FAIL restart_frame: done %0d len %0d first diff %0d expected 1/%0d/-1", ok, got_q.size() - base, FRAME, d);
    end
    n_cmp++; if (done_cnt - dbase != 1) begin n_err++; $display("FAIL restart_done: got %0d pulses expected 1", done_cnt - dbase); end
  endtask

  task automatic test_reset_mid();
    logic [NB_R_INT-1:0] b;
    int base, dbase, cut, d;
    bit ok;
    b = rand_bundle(); fill_mem(1'b0);
    base = got_q.size(); dbase = done_cnt;
    start_frame(b);
    wait_done(base, 1'b0, 1'b0, 1'b0, 100, ok);
    #1;
    n_cmp++; if (o_wr_tx !== 1'b0 || o_busy !== 1'b0 || o_addr !== '0 || o_done !== 1'b0) begin
      n_err++; $display("FAIL abort_outputs: wr %b busy %b addr %0h done %b expected all 0", o_wr_tx, o_busy, o_addr, o_done);
    end
    cut = got_q.size();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() != cut || done_cnt != dbase || !ok) begin
      n_err++; $display("FAIL abort_quiet: extra bytes %0d done pulses %0d expected 0/0", got_q.size() - cut, done_cnt - dbase);
    end
    b = rand_bundle(); build_exp(b);
    base = got_q.size();
    start_frame(b);
    wait_done(base, 1'b0, 1'b0, 1'b0, 0, ok);
    d = first_diff(base);
    n_cmp++; if (!ok || got_q.size() - base !== FRAME || d != -1) begin
      n_err++; $display("FAIL after_abort_frame: done %0d len %0d first diff %0d expected 1/%0d/-1", ok, got_q.size() - base, FRAME, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [NB_R_INT-1:0] b;
    int base, d;
    bit ok;
    for (int f = 0; f < 2; f++) begin
      b = rand_bundle(); fill_mem(1'b0); build_exp(b);
      base = got_q.size();
      start_frame(b);
      wait_done(base, f == 1, 1'b0, 1'b0, 0, ok);
      d = first_diff(base);
      n_cmp++; if (!ok || got_q.size() - base !== FRAME || d != -1) begin
        n_err++; $display("FAIL b2b_frame%0d: done %0d len %0d first diff %0d expected 1/%0d/-1", f, ok, got_q.size() - base, FRAME, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_mutate();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_state_dumper.md
Name: pipe_state_dumper

Overview:
Consumes the halt/step snapshot produced by the MIPS top level and streams it as bytes into the debug unit's UART TX FIFO. On a start pulse it latches the 376-bit concatenated IF/ID, ID/EX, EX/M and M/WB bundle. It then walks the register file and data memory through the shared debug address bus and emits header, bundle bytes, register words and memory words. It sits between the pipeline's debug outputs and the UART transmitter inside the debug path.

Parameters:
NB_REG, 32, data word and debug address width
NB_R_INT, 376, width of latched intermediate-register bundle; must be a multiple of 8
N_REGS, 32, register-file words dumped
N_MEM, 32, data-memory words dumped (word indices 0..N_MEM-1)
HDR_BYTE, 8'hA5, frame start byte

Ports:
i_clk  in  1  system clock (50 MHz domain)
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  one-cycle dump request (halt seen or step completed)
i_reg_int  in  NB_R_INT  {IF_ID, ID_EX, EX_M, M_WB} bundle
i_reg_data  in  NB_REG  register-file read data for o_addr
i_mem_data  in  NB_REG  data-memory read data for o_addr
i_tx_full  in  1  UART TX FIFO full
o_addr  out  NB_REG  word index to register file / data memory
o_wr_tx  out  1  FIFO write strobe, one byte per asserted cycle
o_tx_data  out  8  byte to FIFO
o_busy  out  1  dump in progress
o_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (i_reset=0, async): state IDLE, all outputs 0, counters and shadow cleared.
- FSM states: IDLE, HDR, INT, RD_ADDR, RD_SEND, DONE.
- IDLE: o_busy=0. When i_start=1, latch i_reg_int into the shadow, clear the counters and go to HDR. o_busy=1 from the next cycle.
- Write rule, all send states: o_wr_tx=1 only in a cycle where i_tx_full=0, with o_tx_data valid in that same cycle. If i_tx_full=1, hold o_wr_tx=0 and keep state and data frozen. No byte is ever dropped or duplicated.
- HDR: write HDR_BYTE, then go to INT.
- INT: write NB_R_INT/8 bytes (47 at default), MSB first: shadow[375:368], then [367:360], down to [7:0]. After the last byte go to RD_ADDR with phase=REG and idx=0.
- RD_ADDR: drive o_addr=idx for one cycle with no write. Read data is valid the following cycle. In RD_SEND, capture the word on the first cycle, then send 4 bytes MSB first: [31:24], [23:16], [15:8], [7:0].
- RD_SEND, phase REG: source is i_reg_data.
  - After 4 bytes with idx<N_REGS-1: idx++, go to RD_ADDR.
  - After 4 bytes with idx=N_REGS-1: phase=MEM, idx=0, go to RD_ADDR.
- RD_SEND, phase MEM: source is i_mem_data. Same stepping, up to idx=N_MEM-1, then go to DONE.
- o_addr holds idx throughout RD_ADDR/RD_SEND and is 0 in IDLE.
- DONE: o_done=1 for exactly one cycle, o_busy=0 in the same cycle, then go to IDLE.
- Frame length: 1 + NB_R_INT/8 + 4·N_REGS + 4·N_MEM bytes (304 at defaults).
- i_start while busy (including in DONE) is ignored; the shadow is not reloaded. i_start in the cycle after DONE starts a new frame.
- Reset mid-frame: immediate abort, no further writes, frame not resumed.
- i_reg_int changes after the latch do not affect the frame.

Test Plan:
- Basic dump, i_tx_full=0, bundle = byte-index pattern (0x00..0x2E from MSB), regs[i]=i, mem[i]=0x100+i -> 304 writes. Byte 0=0xA5, bytes 1..47=0x00..0x2E, reg 5 appears as 00 00 00 05, mem 31 as 00 00 01 1F. o_done pulse after the 304th write.
- Backpressure: toggle i_tx_full 1/0 every 3 cycles -> identical 304-byte sequence, o_wr_tx never high while full.
- Bundle mutated after i_start -> emitted bytes match the value at latch time.
- i_start pulsed at bytes 10 and 200 of an active frame -> still exactly 304 bytes, a single o_done.
- Assert i_reset at byte 100 -> outputs 0 immediately, no writes afterwards. A fresh i_start gives a full correct frame.
- Address check: o_addr sequences 0..31 (reg phase) then 0..31 (mem phase), each value held for 5+ cycles when there is no backpressure.
